// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM states and bit-divider helper for the UART message streamer
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - single-frame UART serializer: start, 8 data bits LSB first, optional parity, stop bits
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done,
  output logic       core_busy
);

  localparam int DIV   = uart_div(CLK_HZ, BAUD);
  localparam int NBITS = 10 + ((PARITY != PAR_NONE) ? 1 : 0) + STOP_BITS - 1;
  localparam int CW    = $clog2(DIV);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bits_left;
  logic [9:0]    shreg;
  logic          par_bit;

  // Without parity, slot 8 just carries the first stop bit.
  always_comb begin
    par_bit = 1'b1;
    if (PARITY == PAR_EVEN) par_bit = ^data;
    else if (PARITY == PAR_ODD) par_bit = ~^data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx         <= 1'b1;
      frame_done <= 1'b0;
      core_busy  <= 1'b0;
      baud_cnt   <= '0;
      bits_left  <= '0;
      shreg      <= '1;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        tx        <= 1'b0;
        core_busy <= 1'b1;
        baud_cnt  <= '0;
        bits_left <= 4'(NBITS - 1);
        shreg     <= {1'b1, par_bit, data};
      end else if (core_busy) begin
        if (baud_cnt == CW'(DIV - 1)) begin
          baud_cnt <= '0;
          if (bits_left == 4'd0) begin
            core_busy  <= 1'b0;
            frame_done <= 1'b1;
            tx         <= 1'b1;
          end else begin
            tx        <= shreg[0];
            shreg     <= {1'b1, shreg[9:1]};
            bits_left <= bits_left - 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_msg_streamer.sv
// rtl/uart_msg_streamer.sv - buffered UART message transmitter with repeat, idle gap and clean abort
module uart_msg_streamer
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200,
  parameter int DEPTH     = 16,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk_12m,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   msg_len,
  input  logic          start,
  input  logic          repeat_en,
  input  logic          abort,
  output logic          tx,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] char_idx
);

  localparam int DIV     = uart_div(CLK_HZ, BAUD);
  localparam int GAP_CYC = GAP_BITS * DIV;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_msg_streamer: clocks per bit must be at least 2");
  end
  if (DEPTH < 2) begin : g_depth_check
    $error("uart_msg_streamer: DEPTH must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_parity_check
    $error("uart_msg_streamer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_msg_streamer: STOP_BITS must be 1 or 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data;
  state_t        state;
  logic [AW:0]   len;
  logic [GW-1:0] gap_cnt;
  logic          abort_q;
  logic          load;
  logic          frame_done;
  logic          core_busy;

  // Registered read: a same-cycle write to the fetched address is seen next time.
  always_ff @(posedge clk_12m) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (state == ST_FETCH) rd_data <= mem[char_idx];
  end

  assign load = (state == ST_LOAD) && !core_busy;

  always_ff @(posedge clk_12m or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      char_idx <= '0;
      gap_cnt  <= '0;
      abort_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && abort) abort_q <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (start && msg_len != '0) begin
            len      <= msg_len;
            char_idx <= '0;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: if (!core_busy) state <= ST_SEND;
        ST_SEND: begin
          if (frame_done) begin
            if (abort_q || abort) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else if ((AW+1)'(char_idx) + (AW+1)'(1) < len) begin
              char_idx <= char_idx + 1'b1;
              state    <= ST_FETCH;
            end else if (repeat_en) begin
              if (GAP_CYC == 0) begin
                char_idx <= '0;
                state    <= ST_FETCH;
              end else begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (abort_q || abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (gap_cnt == GW'(GAP_CYC - 1)) begin
            char_idx <= '0;
            state    <= ST_FETCH;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_core #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_core (
    .clk       (clk_12m),
    .rst       (rst),
    .load      (load),
    .data      (rd_data),
    .tx        (tx),
    .frame_done(frame_done),
    .core_busy (core_busy)
  );

endmodule

// File: tb/tb_uart_msg_streamer.sv
// tb/tb_uart_msg_streamer.sv - directed checks of framing, spacing, repeat gap, abort, buffer writes and reset
`timescale 1ns/1ps
module tb_uart_msg_streamer;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] msg_len;
  logic [2:0] start_v;
  logic       repeat_en;
  logic       abort;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [3:0] ci [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // u0: no parity, 1 stop; u1: even parity, 2 stop, 3-bit gap; u2: odd parity, 1 stop.
  uart_msg_streamer #(.CLK_HZ(800), .BAUD(100), .DEPTH(16), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0)) u0 (
    .clk_12m(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .msg_len(msg_len),
    .start(start_v[0]), .repeat_en(repeat_en), .abort(abort), .tx(tx_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .char_idx(ci[0]));
  uart_msg_streamer #(.CLK_HZ(800), .BAUD(100), .DEPTH(16), .PARITY(1), .STOP_BITS(2), .GAP_BITS(3)) u1 (
    .clk_12m(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .msg_len(msg_len),
    .start(start_v[1]), .repeat_en(repeat_en), .abort(abort), .tx(tx_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .char_idx(ci[1]));
  uart_msg_streamer #(.CLK_HZ(800), .BAUD(100), .DEPTH(16), .PARITY(2), .STOP_BITS(1), .GAP_BITS(0)) u2 (
    .clk_12m(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .msg_len(msg_len),
    .start(start_v[2]), .repeat_en(repeat_en), .abort(abort), .tx(tx_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .char_idx(ci[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  // Ticks until tx of instance k goes low; n = ticks taken, -1 if the bound expires.
  task automatic wait_start(input int k, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      start_v = '0;
      if (tx_v[k] === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  // Entered on the first start-bit cycle; leaves on the last cycle of the last stop bit.
  task automatic check_frame(input int k, input logic [11:0] bits, input int nb,
                             input int abort_at, input int wr_at, input string tag);
    int hits;
    int idx;
    idx = 0;
    for (int b = 0; b < nb; b++) begin
      hits = 0;
      for (int c = 0; c < DIV; c++) begin
        if (idx != 0) tick();
        if (idx == abort_at) abort = 1'b1;
        else if (idx == abort_at + 1) abort = 1'b0;
        if (idx == wr_at) wr_en = 1'b1;
        else if (idx == wr_at + 1) wr_en = 1'b0;
        if (tx_v[k] === bits[b]) hits++;
        idx++;
      end
      check($sformatf("%s bit%0d", tag, b), hits, DIV);
    end
  endtask

  task automatic expect_done(input int k, input string tag);
    tick();
    check({tag, " done early"}, done_v[k], 0);
    check({tag, " busy tail"}, busy_v[k], 1);
    tick();
    check({tag, " done"}, done_v[k], 1);
    check({tag, " busy off"}, busy_v[k], 0);
    check({tag, " tx idle"}, tx_v[k], 1);
    tick();
    check({tag, " done once"}, done_v[k], 0);
  endtask

  task automatic quiet(input int k, input int cycles, input string tag);
    int lows;
    int busys;
    int dones;
    lows = 0;
    busys = 0;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      start_v = '0;
      if (tx_v[k] !== 1'b1) lows++;
      if (busy_v[k] !== 1'b0) busys++;
      if (done_v[k] !== 1'b0) dones++;
    end
    check({tag, " tx low cycles"}, lows, 0);
    check({tag, " busy cycles"}, busys, 0);
    check({tag, " done cycles"}, dones, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] byte_exp;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    start_v = '0; repeat_en = 1'b0; abort = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset tx%0d", k), tx_v[k], 1);
      check($sformatf("reset busy%0d", k), busy_v[k], 0);
      check($sformatf("reset done%0d", k), done_v[k], 0);
      check($sformatf("reset idx%0d", k), ci[k], 0);
    end
    rst = 1'b0;
    tick();

    // "Hi", no parity: latency 3, back-to-back frames 3 idle cycles apart.
    wr(4'd0, 8'h48);
    wr(4'd1, 8'h69);
    msg_len = 5'd2;
    start_v[0] = 1'b1;
    wait_start(0, 20, n);
    check("t1 latency", n, 3);
    check("t1 busy", busy_v[0], 1);
    check("t1 idx0", ci[0], 0);
    check_frame(0, 12'({1'b1, 8'h48, 1'b0}), 10, -1, -1, "t1 H");
    wait_start(0, 20, n);
    check("t1 spacing", n, 4);
    check("t1 idx1", ci[0], 1);
    check_frame(0, 12'({1'b1, 8'h69, 1'b0}), 10, -1, -1, "t1 i");
    expect_done(0, "t1");

    // 0x07 with even parity and 2 stop bits, then odd parity.
    wr(4'd0, 8'h07);
    msg_len = 5'd1;
    start_v[1] = 1'b1;
    wait_start(1, 20, n);
    check("t2 even latency", n, 3);
    check_frame(1, {2'b11, 1'b1, 8'h07, 1'b0}, 12, -1, -1, "t2 even");
    expect_done(1, "t2 even");
    start_v[2] = 1'b1;
    wait_start(2, 20, n);
    check("t2 odd latency", n, 3);
    check_frame(2, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 11, -1, -1, "t2 odd");
    expect_done(2, "t2 odd");

    // Repeat with a 3-bit gap, then drop repeat_en for one final message.
    wr(4'd0, 8'h48);
    wr(4'd1, 8'h69);
    msg_len = 5'd2;
    repeat_en = 1'b1;
    start_v[1] = 1'b1;
    wait_start(1, 20, n);
    check("t3 latency", n, 3);
    check_frame(1, {2'b11, 1'b0, 8'h48, 1'b0}, 12, -1, -1, "t3 m0b0");
    wait_start(1, 20, n);
    check("t3 spacing", n, 4);
    check_frame(1, {2'b11, 1'b0, 8'h69, 1'b0}, 12, -1, -1, "t3 m0b1");
    wait_start(1, 60, n);
    check("t3 gap", n, 28);
    check("t3 wrap idx", ci[1], 0);
    check("t3 busy in repeat", busy_v[1], 1);
    repeat_en = 1'b0;
    check_frame(1, {2'b11, 1'b0, 8'h48, 1'b0}, 12, -1, -1, "t3 m1b0");
    wait_start(1, 20, n);
    check("t3 spacing2", n, 4);
    check("t3 idx1", ci[1], 1);
    check_frame(1, {2'b11, 1'b0, 8'h69, 1'b0}, 12, -1, -1, "t3 m1b1");
    expect_done(1, "t3");
    quiet(1, 40, "t3 after");

    // Abort mid-frame completes byte 0 only; abort during the gap ends at once.
    wr(4'd0, 8'h55);
    wr(4'd1, 8'hA5);
    wr(4'd2, 8'h0F);
    wr(4'd3, 8'hF0);
    msg_len = 5'd4;
    start_v[0] = 1'b1;
    wait_start(0, 20, n);
    check("t4 latency", n, 3);
    check_frame(0, 12'({1'b1, 8'h55, 1'b0}), 10, 30, -1, "t4 b0");
    expect_done(0, "t4");
    quiet(0, 40, "t4 after");
    msg_len = 5'd1;
    repeat_en = 1'b1;
    start_v[1] = 1'b1;
    wait_start(1, 20, n);
    check("t4g latency", n, 3);
    check_frame(1, {2'b11, 1'b0, 8'h55, 1'b0}, 12, -1, -1, "t4g b0");
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat_en = 1'b0;
    check("t4g done", done_v[1], 1);
    check("t4g busy", busy_v[1], 0);
    quiet(1, 40, "t4g after");

    // Zero-length start ignored; full 16-byte message with a live write to address 3.
    msg_len = 5'd0;
    start_v[0] = 1'b1;
    quiet(0, 12, "t5 zero");
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h30 + 8'(i));
    wr_addr = 4'd3;
    wr_data = 8'hC3;
    msg_len = 5'd16;
    start_v[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_start(0, 20, n);
      check($sformatf("t5 spacing%0d", i), n, (i == 0) ? 3 : 4);
      check($sformatf("t5 idx%0d", i), ci[0], i);
      byte_exp = (i == 3) ? 8'hC3 : 8'h30 + 8'(i);
      check_frame(0, 12'({1'b1, byte_exp, 1'b0}), 10, -1, (i == 1) ? 40 : -1,
                  $sformatf("t5 b%0d", i));
    end
    expect_done(0, "t5");

    // Reset mid-frame, then a clean full frame.
    msg_len = 5'd2;
    start_v[0] = 1'b1;
    wait_start(0, 20, n);
    check("t6 latency", n, 3);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    #1;
    check("t6 tx async", tx_v[0], 1);
    check("t6 busy async", busy_v[0], 0);
    tick();
    check("t6 no done", done_v[0], 0);
    rst = 1'b0;
    tick();
    msg_len = 5'd1;
    start_v[0] = 1'b1;
    wait_start(0, 20, n);
    check("t6 latency2", n, 3);
    check_frame(0, 12'({1'b1, 8'h30, 1'b0}), 10, -1, -1, "t6 b0");
    expect_done(0, "t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_msg_streamer.md
Name: uart_msg_streamer

Overview:
Parametrised UART message transmitter. Holds a writable message buffer of DEPTH bytes and streams the first msg_len bytes as 8-bit UART frames on tx. Frames have configurable parity and stop bits. The block supports one-shot or repeating transmission with a configurable idle gap between repetitions, plus a clean abort. It sits between board-level control logic and the DEV_TX pin and replaces the fixed "Hello world!" streaming path.

Parameters:
CLK_HZ, 12000000, input clock frequency in Hz.
BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit (rounded; 104 at defaults); DIV >= 2 is required (elaboration error otherwise).
DEPTH, 16, message buffer bytes, >= 2; AW = clog2(DEPTH) (localparam).
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame, 1 or 2.
GAP_BITS, 0, idle bit periods (tx = 1) inserted between repetitions in repeat mode.

Ports:
clk_12m  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer write address
wr_data  in  8  buffer write data
msg_len  in  AW+1  bytes per message, 0..DEPTH; sampled on accepted start
start  in  1  begin a message (level or pulse); accepted only in IDLE
repeat_en  in  1  sampled at end of each message; 1 = restart after the gap
abort  in  1  stop after the current frame completes
tx  out  1  serial line, idle high
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse on return to IDLE
char_idx  out  AW  index of the byte currently being sent

Behaviour:
- Clock and reset: one clock, clk_12m. Reset is asynchronous and active-high (rst).
- Reset values: tx = 1, busy = 0, done = 0, char_idx = 0. FSM goes to IDLE and the abort latch clears. Buffer contents are not reset.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); no done pulse.
- Buffer: 1 write port, 1 registered read port. A same-cycle write and read of the same address returns the old data. Writes are allowed while busy; bytes not yet fetched take the new value.
- FSM states:
  - IDLE: start && msg_len != 0 -> FETCH; latch msg_len; char_idx = 0. start with msg_len == 0 is ignored: no busy, no done.
  - FETCH: 1 cycle; issue read of char_idx.
  - LOAD: 1 cycle; pass the byte to the serializer. tx falls on the following cycle, so start is accepted in cycle N and tx = 0 in cycle N+3.
  - SEND: wait for the serializer frame-done pulse, then:
    - abort latched -> IDLE.
    - else if char_idx < len-1 -> char_idx+1, FETCH.
    - else if repeat_en -> GAP (or FETCH with char_idx = 0 when GAP_BITS = 0).
    - else -> IDLE.
  - GAP: GAP_BITS*DIV cycles with tx = 1. Then char_idx = 0 and -> FETCH. abort during GAP -> IDLE immediately.
- Abort: an abort pulse anywhere while busy is latched until IDLE. It never truncates a frame.
- Frame format: start bit 0, data bits LSB first, optional parity bit, STOP_BITS ones.
  - Every bit lasts exactly DIV cycles. The baud counter restarts at each frame load, with no phase drift from a free-running divider.
  - Frame length = (10 + (PARITY != 0) + STOP_BITS - 1) * DIV cycles.
- Inter-frame spacing within a message: back-to-back. The next start bit follows the last stop bit after exactly 3 cycles (SEND -> FETCH -> LOAD).
- done pulses on the cycle the FSM enters IDLE; busy deasserts in that same cycle.
- A start that is held high re-triggers on the next IDLE cycle. This behaviour is intended.

Decomposition:
- Shared package uart_pkg:
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - FSM state enum.
  - function computing DIV from CLK_HZ and BAUD.
- Sub-module uart_tx_core (CLK_HZ, BAUD, PARITY, STOP_BITS):
  - inputs load and data[7:0].
  - outputs tx, frame_done (1-cycle pulse at the end of the last stop bit) and core_busy.
  - contains the baud counter and shift register.
- The top level holds the buffer, the FSM and the gap counter.

Test Plan:
1. CLK_HZ=800, BAUD=100 (DIV=8), PARITY=0. Write "Hi" (0x48, 0x69), msg_len=2, pulse start at cycle N -> tx low at N+3. tx carries 0,0,0,0,1,0,0,1,0,1 for 8 cycles each, then the second frame starts 3 cycles after. done pulses once, busy drops with it.
2. PARITY=1, then PARITY=2, sending 0x07 -> parity bit 1 (even) or 0 (odd). STOP_BITS=2 -> line high for 16 cycles after the parity bit. Total frame length matches the formula.
3. repeat_en=1, GAP_BITS=3, msg_len=2 -> after byte 1's stop bit, tx stays high exactly 24+3 cycles, then byte 0 resends. char_idx wraps 1 -> 0. Drop repeat_en -> exactly one more message, then done.
4. abort pulsed mid-way through byte 0 of a 4-byte message -> byte 0 completes in full, no byte 1 is sent, done pulses, tx = 1. abort during GAP -> immediate IDLE.
5. start with msg_len=0 -> busy, done and tx unchanged. msg_len=DEPTH=16 -> all 16 bytes sent, char_idx reaches 15. A write to address 3 while byte 1 is in flight -> the new value is transmitted.
6. Assert rst mid-frame -> tx=1, busy=0 the same cycle. Release rst, then start -> a clean, full-length first frame.
